mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and register width; only 32 is supported.
REQ-002 clk  in  1: single clock; all state updates on rising edge.
REQ-003 reset  in  1: synchronous, active-high reset.
REQ-004 start  in  1: request a multiply; sampled only in IDLE.
REQ-005 op  in  2: 00 MUL, 01 UMULL, 10 SMULL, 11 reserved (executes as MUL).
REQ-006 a, b  in  WIDTH each: multiplicand and multiplier.
REQ-007 rdlo, rdhi  in  4 each: destination register addresses for the low and high result words.
REQ-008 busy  out  1: high from the cycle after acceptance through the DONE cycle inclusive.
REQ-009 done  out  1: single-cycle pulse marking valid results.
REQ-010 wd_lo, wd_hi  out  WIDTH each: result words; feed regfile wd3 and wd4.
REQ-011 wa_lo, wa_hi  out  4 each: captured rdlo and rdhi; feed regfile wa3 and wa4.
REQ-012 we_lo, we_hi  out  1 each: write enables; feed regfile we3 and we4.

Function
REQ-013 FSM states IDLE, RUN, DONE.
- IDLE->RUN on start.
- RUN->DONE when the iteration counter reaches 31.
- DONE->IDLE unconditionally.
REQ-014 On acceptance, a, b, op, rdlo and rdhi are captured; later input changes have no effect on the operation in flight.
REQ-015 RUN performs one shift-add iteration per cycle, exactly 32 cycles. A 5-bit counter cleared on acceptance wraps 31->0 on the RUN->DONE transition.
REQ-016 Latency: start sampled at edge N gives done=1 in the cycle after edge N+33; no other cycle has done=1.
REQ-017 MUL (and op 11):
- wd_lo = low 32 bits of a*b; overflow is discarded silently.
- we_lo=1 and we_hi=0 in DONE.
REQ-018 UMULL: {wd_hi,wd_lo} = unsigned 64-bit a*b; we_lo=we_hi=1 in DONE.
REQ-019 SMULL: {wd_hi,wd_lo} = signed 64-bit a*b.
- Done by magnitude multiply plus a final two's-complement negate when operand signs differ.
- The negate adds no cycle.
- we_lo=we_hi=1 in DONE.
REQ-020 we_lo and we_hi are 0 in every state except DONE.
REQ-021 wd_*, wa_* hold their last values outside DONE; they are valid only while done=1.
REQ-022 start while busy=1 is ignored, not queued; start in the DONE cycle is ignored.
REQ-023 rdlo==rdhi on long ops: both enables still assert; the regfile's port-4 priority makes wd_hi land.
REQ-024 start and reset high at the same edge: reset wins; the operation is not accepted.

Reset
REQ-025 Reset at any state, including mid-RUN, forces IDLE within one edge.
REQ-026 Reset clears the counter, busy, done, we_lo, we_hi, wd_lo, wd_hi, wa_lo and wa_hi to 0.
REQ-027 A reset-aborted operation produces no done pulse and no write enable.

Structure
REQ-028 The op encodings (MUL/UMULL/SMULL) and the FSM state enum live in the shared package used by the controller.
REQ-029 The block is a single module with no sub-modules; the 64-bit accumulator and operand registers are local.
REQ-030 The datapath mux selecting ALU versus mul_unit writes is outside this block.

Verification
REQ-031 UMULL a=0xFFFFFFFF, b=0xFFFFFFFF, rdlo=2, rdhi=3 -> done at N+33; wd_hi=0xFFFFFFFE, wd_lo=0x00000001; wa_lo=2, wa_hi=3; both enables high.
REQ-032 SMULL a=0xFFFFFFFE (-2), b=3 -> wd_hi=0xFFFFFFFF, wd_lo=0xFFFFFFFA.
- SMULL a=b=0x80000000 -> wd_hi=0x40000000, wd_lo=0.
REQ-033 MUL a=0x00010000, b=0x00010000 -> wd_lo=0, we_lo=1, we_hi=0.
- MUL 7*6 -> wd_lo=42.
REQ-034 Start UMULL 5*5, then pulse start with a=9 during RUN cycle 10 -> single done; result 25; busy stays high throughout.
REQ-035 Start SMULL, assert reset at RUN cycle 10 -> next cycle IDLE and all outputs 0; no done within 40 cycles.
- A new MUL 3*4 then completes with 12.
REQ-036 start and reset high at the same edge -> busy stays 0; no done.

Source files
------------

// File: rtl/mul_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier: op encodings,
// controller state enum and the iteration bound.
package mul_unit_pkg;

  // Number of shift-add iterations is 32; the counter ends on this value.
  localparam int          CNT_W     = 5;
  localparam logic [4:0]  LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_RSVD  = 2'b11   // executes as MUL
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Long ops write both the low and the high result word.
  function automatic logic is_long(input op_e op);
    return (op == OP_UMULL) || (op == OP_SMULL);
  endfunction

endpackage

// File: rtl/mul_unit.sv
// Iterative 32x32 multiplier (MUL / UMULL / SMULL), one shift-add step per
// cycle. Signed products use magnitudes plus a final negate folded into the
// result register load, so the signed path costs no extra cycle.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       rdlo,
  input  logic [3:0]       rdhi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] wd_lo,
  output logic [WIDTH-1:0] wd_hi,
  output logic [3:0]       wa_lo,
  output logic [3:0]       wa_hi,
  output logic             we_lo,
  output logic             we_hi
);

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic               neg_reg;
  op_e                op_reg;
  logic [3:0]         rdlo_reg, rdhi_reg;

  logic               accept;
  logic               iterate;
  logic               finish;
  logic               is_smull_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] product;

  // Operand magnitudes for the signed path; unsigned ops pass straight through.
  assign is_smull_in = (op_e'(op) == OP_SMULL);
  assign mag_a = (is_smull_in && a[WIDTH-1]) ? (~a + ONE_W) : a;
  assign mag_b = (is_smull_in && b[WIDTH-1]) ? (~b + ONE_W) : b;

  // Final product: negate the magnitude product when operand signs differed.
  assign product = neg_reg ? (~acc_reg + ONE_2W) : acc_reg;

  // Busy covers the whole run and the visible done cycle.
  assign busy = (state_reg != ST_IDLE) || done;

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Controller next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (count_reg == LAST_ITER) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Controller outputs; a start during the done cycle is not accepted.
  always_comb begin
    accept  = (state_reg == ST_IDLE) && start && !done;
    iterate = (state_reg == ST_RUN);
    finish  = (state_reg == ST_DONE);
  end

  // Operand capture and one shift-add iteration per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      neg_reg    <= 1'b0;
      op_reg     <= OP_MUL;
      rdlo_reg   <= '0;
      rdhi_reg   <= '0;
    end else if (accept) begin
      count_reg  <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
      mplier_reg <= mag_b;
      acc_reg    <= '0;
      neg_reg    <= is_smull_in && (a[WIDTH-1] ^ b[WIDTH-1]);
      op_reg     <= op_e'(op);
      rdlo_reg   <= rdlo;
      rdhi_reg   <= rdhi;
    end else if (iterate) begin
      count_reg  <= count_reg + 5'd1;
      if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
    end
  end

  // Result and write-port registers; loaded once per operation, pulsed enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      done  <= 1'b0;
      we_lo <= 1'b0;
      we_hi <= 1'b0;
      wd_lo <= '0;
      wd_hi <= '0;
      wa_lo <= '0;
      wa_hi <= '0;
    end else begin
      done  <= 1'b0;
      we_lo <= 1'b0;
      we_hi <= 1'b0;
      if (finish) begin
        done  <= 1'b1;
        we_lo <= 1'b1;
        we_hi <= is_long(op_reg);
        wd_lo <= product[WIDTH-1:0];
        if (is_long(op_reg)) wd_hi <= product[2*WIDTH-1:WIDTH];
        wa_lo <= rdlo_reg;
        wa_hi <= rdhi_reg;
      end
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner vectors, randomized ops
// against an arithmetic reference model, busy/ignore-start, and reset abort.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [3:0]  rdlo, rdhi;
  logic        busy, done;
  logic [31:0] wd_lo, wd_hi;
  logic [3:0]  wa_lo, wa_hi;
  logic        we_lo, we_hi;

  int total = 0;
  int bad   = 0;

  mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rdlo(rdlo), .rdhi(rdhi), .busy(busy), .done(done),
    .wd_lo(wd_lo), .wd_hi(wd_hi), .wa_lo(wa_lo), .wa_hi(wa_hi),
    .we_lo(we_lo), .we_hi(we_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition of each op.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] u;
    logic [31:0] lo;
    case (o)
      2'b01: begin u = {32'h0, x} * {32'h0, y}; return u; end
      2'b10: begin sx = $signed(x); sy = $signed(y); return 64'(sx * sy); end
      default: begin lo = x * y; return {32'h0, lo}; end
    endcase
  endfunction

  // One operation: accept, scramble inputs, optional start pulse mid-run,
  // wait for done (bounded), check results, then try a start in the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [3:0] la, input logic [3:0] ha, input int pulse_at,
                       input logic [63:0] exp);
    int lat;
    bit lng;
    lat = 0;
    lng = (o == 2'b01) || (o == 2'b10);
    start = 1'b1; op = o; a = av; b = bv; rdlo = la; rdhi = ha;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom); rdlo = 4'($urandom); rdhi = 4'($urandom);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (k == pulse_at) begin start = 1'b1; a = 32'd9; end
      if (k == pulse_at + 1) start = 1'b0;
      @(posedge clk); #1;
      if (done) lat = k;
      else check("run_busy_we", 64'({busy, we_lo, we_hi}), 64'b100);
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'd33);
    if (lat != 0) begin
      check("wd_lo", 64'(wd_lo), 64'(exp[31:0]));
      if (lng) check("wd_hi", 64'(wd_hi), 64'(exp[63:32]));
      check("wa", 64'({wa_hi, wa_lo}), 64'({ha, la}));
      check("we_busy", 64'({we_lo, we_hi, busy}), 64'({1'b1, lng, 1'b1}));
    end
    $display("txn op=%0d a=%08h b=%08h lat=%0d wd_hi=%08h wd_lo=%08h exp=%016h",
             o, av, bv, lat, wd_hi, wd_lo, exp);
    start = 1'b1; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("after_done_idle", 64'({done, busy, we_lo, we_hi}), 64'd0);
  endtask

  task automatic quiet_window(input string tag);
    int n;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || we_lo || we_hi || busy) n++;
    end
    check(tag, 64'(n), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; rdlo = '0; rdhi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", 64'({busy, done, we_lo, we_hi, wa_lo, wa_hi}), 64'd0);
    check("reset_wd", {wd_hi, wd_lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed corner vectors.
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 4'd3, -1, 64'hFFFF_FFFE_0000_0001);
    do_op(2'b10, 32'hFFFF_FFFE, 32'd3,         4'd4, 4'd5, -1, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(2'b10, 32'h8000_0000, 32'h8000_0000, 4'd6, 4'd7, -1, 64'h4000_0000_0000_0000);
    do_op(2'b00, 32'h0001_0000, 32'h0001_0000, 4'd8, 4'd9, -1, 64'd0);
    do_op(2'b00, 32'd7,         32'd6,         4'd1, 4'd0, -1, 64'd42);
    do_op(2'b01, 32'd7,         32'd9,         4'd5, 4'd5, -1, 64'd63);

    // Start pulse during RUN cycle 10 is ignored.
    do_op(2'b01, 32'd5, 32'd5, 4'd1, 4'd2, 10, 64'd25);

    // Randomized ops against the reference model (op 11 runs as MUL).
    for (int i = 0; i < 14; i++) begin
      ro = 2'($urandom); ra = pick(); rb = pick();
      do_op(ro, ra, rb, 4'($urandom), 4'($urandom), -1, model(ro, ra, rb));
    end

    // Reset in RUN cycle 10 aborts with no done and cleared outputs.
    start = 1'b1; op = 2'b10; a = 32'hFFFF_FFF0; b = 32'd77; rdlo = 4'd3; rdhi = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ctl", 64'({busy, done, we_lo, we_hi, wa_lo, wa_hi}), 64'd0);
    check("abort_wd", {wd_hi, wd_lo}, 64'd0);
    $display("txn reset abort of SMULL at run cycle 10");
    quiet_window("abort_quiet");
    do_op(2'b00, 32'd3, 32'd4, 4'd2, 4'd3, -1, 64'd12);

    // Start and reset at the same edge: reset wins.
    start = 1'b1; reset = 1'b1; op = 2'b01; a = 32'd11; b = 32'd13;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    check("start_reset_busy", 64'(busy), 64'd0);
    $display("txn start with reset at same edge");
    quiet_window("start_reset_quiet");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
